// File: rtl/gshare_btb_predictor.sv
// gshare direction predictor with a direct-mapped BTB and a speculative global history
// that is repaired from the EX-supplied snapshot on a mispredict.
module gshare_btb_predictor #(
  parameter int         GHR_BITS    = 8,
  parameter int         BHT_ENTRIES = 256,
  parameter int         BTB_ENTRIES = 64,
  parameter int         TAG_BITS    = 10,
  parameter logic [1:0] CTR_INIT    = 2'b01
) (
  input  logic                clk,
  input  logic                reset,
  output logic                ready,
  input  logic                pred_valid,
  input  logic [31:0]         pred_pc,
  output logic                pred_hit,
  output logic                pred_taken,
  output logic [31:0]         pred_target,
  output logic [GHR_BITS-1:0] pred_ghr,
  input  logic                upd_valid,
  input  logic [31:0]         upd_pc,
  input  logic [GHR_BITS-1:0] upd_ghr,
  input  logic                upd_taken,
  input  logic [31:0]         upd_target,
  input  logic                upd_mispredict
);

  localparam int IDX_BITS = $clog2(BHT_ENTRIES);
  localparam int BIDX     = $clog2(BTB_ENTRIES);

  typedef enum logic {INIT = 1'b0, RUN = 1'b1} state_t;

  state_t                state, state_next;
  logic [IDX_BITS-1:0]   sweep, sweep_next;
  logic [GHR_BITS-1:0]   spec_ghr;
  logic [1:0]            bht [BHT_ENTRIES];
  logic [BTB_ENTRIES-1:0] btb_valid;
  logic [TAG_BITS-1:0]   btb_tag [BTB_ENTRIES];
  logic [31:0]           btb_target [BTB_ENTRIES];

  logic                  run;
  logic [IDX_BITS-1:0]   pidx, uidx;
  logic [BIDX-1:0]       pbidx, ubidx;
  logic [TAG_BITS-1:0]   ptag, utag;
  logic                  lookup_hit;
  logic                  unused_bits;

  function automatic logic [1:0] ctr_next(input logic [1:0] ctr, input logic taken);
    if (taken) begin
      return (ctr == 2'b11) ? 2'b11 : ctr + 2'b01;
    end else begin
      return (ctr == 2'b00) ? 2'b00 : ctr - 2'b01;
    end
  endfunction

  assign run   = (state == RUN);
  assign ready = run;

  assign pidx  = pred_pc[IDX_BITS+1:2] ^ IDX_BITS'(spec_ghr);
  assign uidx  = upd_pc[IDX_BITS+1:2] ^ IDX_BITS'(upd_ghr);
  assign pbidx = pred_pc[BIDX+1:2];
  assign ubidx = upd_pc[BIDX+1:2];
  assign ptag  = pred_pc[BIDX+2 +: TAG_BITS];
  assign utag  = upd_pc[BIDX+2 +: TAG_BITS];

  assign lookup_hit  = btb_valid[pbidx] && (btb_tag[pbidx] == ptag);
  assign unused_bits = ^{pred_pc, upd_pc, upd_ghr};

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= INIT;
      sweep <= '0;
    end else begin
      state <= state_next;
      sweep <= sweep_next;
    end
  end

  always_comb begin
    state_next = state;
    sweep_next = sweep;
    case (state)
      INIT: begin
        if (sweep == IDX_BITS'(BHT_ENTRIES - 1)) begin
          state_next = RUN;
          sweep_next = '0;
        end else begin
          sweep_next = sweep + IDX_BITS'(1);
        end
      end
      RUN: begin
        state_next = RUN;
        sweep_next = '0;
      end
      default: begin
        state_next = INIT;
        sweep_next = '0;
      end
    endcase
  end

  // Lookup reads pre-update tables; everything is forced to zero until the sweep finishes.
  always_comb begin
    pred_hit    = 1'b0;
    pred_taken  = 1'b0;
    pred_target = 32'd0;
    pred_ghr    = '0;
    if (run) begin
      pred_hit    = lookup_hit;
      pred_taken  = lookup_hit & bht[pidx][1];
      pred_target = lookup_hit ? btb_target[pbidx] : 32'd0;
      pred_ghr    = spec_ghr;
    end else begin
      pred_hit    = 1'b0;
      pred_taken  = 1'b0;
      pred_target = 32'd0;
      pred_ghr    = '0;
    end
  end

  // A mispredict repair wins over the same-cycle speculative shift.
  always_ff @(posedge clk) begin
    if (reset) begin
      spec_ghr <= '0;
    end else if (run) begin
      if (upd_valid && upd_mispredict) begin
        spec_ghr <= {upd_ghr[GHR_BITS-2:0], upd_taken};
      end else if (pred_valid && lookup_hit) begin
        spec_ghr <= {spec_ghr[GHR_BITS-2:0], pred_taken};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && !run) begin
      bht[sweep] <= CTR_INIT;
    end else if (!reset && upd_valid) begin
      bht[uidx] <= ctr_next(bht[uidx], upd_taken);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      btb_valid <= '0;
    end else if (run && upd_valid && upd_taken) begin
      btb_valid[ubidx] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && run && upd_valid && upd_taken) begin
      btb_tag[ubidx]    <= utag;
      btb_target[ubidx] <= upd_target;
    end
  end

endmodule

// File: tb/tb_gshare_btb_predictor.sv
// Directed bench: stimulus queues expected outputs per cycle, a negedge monitor pops and compares.
module tb_gshare_btb_predictor;

  logic        clk = 1'b0;
  logic        reset;
  logic        ready;
  logic        pred_valid;
  logic [31:0] pred_pc;
  logic        pred_hit;
  logic        pred_taken;
  logic [31:0] pred_target;
  logic [7:0]  pred_ghr;
  logic        upd_valid;
  logic [31:0] upd_pc;
  logic [7:0]  upd_ghr;
  logic        upd_taken;
  logic [31:0] upd_target;
  logic        upd_mispredict;

  gshare_btb_predictor dut (
    .clk(clk), .reset(reset), .ready(ready),
    .pred_valid(pred_valid), .pred_pc(pred_pc), .pred_hit(pred_hit),
    .pred_taken(pred_taken), .pred_target(pred_target), .pred_ghr(pred_ghr),
    .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_ghr(upd_ghr),
    .upd_taken(upd_taken), .upd_target(upd_target), .upd_mispredict(upd_mispredict)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          cyc;
    string       name;
    logic        rdy;
    logic        hit;
    logic        tkn;
    logic [31:0] tgt;
    logic [7:0]  ghr;
  } exp_t;

  exp_t q[$];
  exp_t mon_e;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    while (q.size() > 0 && q[0].cyc <= cyc) begin
      mon_e = q.pop_front();
      n_checks++;
      if (mon_e.cyc != cyc ||
          {ready, pred_hit, pred_taken, pred_target, pred_ghr} !==
          {mon_e.rdy, mon_e.hit, mon_e.tkn, mon_e.tgt, mon_e.ghr}) begin
        n_fail++;
        $display("FAIL %s cyc=%0d: got rdy=%b hit=%b tkn=%b tgt=%h ghr=%h, want rdy=%b hit=%b tkn=%b tgt=%h ghr=%h",
                 mon_e.name, cyc, ready, pred_hit, pred_taken, pred_target, pred_ghr,
                 mon_e.rdy, mon_e.hit, mon_e.tkn, mon_e.tgt, mon_e.ghr);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_out(input string name, input logic rdy, input logic hit, input logic tkn,
                            input logic [31:0] tgt, input logic [7:0] ghr);
    exp_t e;
    e.cyc = cyc; e.name = name; e.rdy = rdy; e.hit = hit; e.tkn = tkn; e.tgt = tgt; e.ghr = ghr;
    q.push_back(e);
  endtask

  task automatic upd(input logic [31:0] pc, input logic [7:0] ghr, input logic taken,
                     input logic [31:0] tgt, input logic misp);
    upd_valid = 1'b1; upd_pc = pc; upd_ghr = ghr; upd_taken = taken;
    upd_target = tgt; upd_mispredict = misp;
  endtask

  // Activity that must be ignored while the tables are being initialised.
  task automatic garbage();
    pred_valid = 1'b1; pred_pc = 32'h100;
    upd(32'h100, 8'hFF, 1'b1, 32'h80, 1'b1);
  endtask

  task automatic idle();
    pred_valid = 1'b0; pred_pc = 32'h0;
    upd_valid = 1'b0; upd_pc = 32'h0; upd_ghr = 8'h0; upd_taken = 1'b0;
    upd_target = 32'h0; upd_mispredict = 1'b0;
  endtask

  task automatic sweep_check();
    for (int i = 1; i <= 256; i++) begin
      step();
      if (i == 1 || i == 128 || i == 255) expect_out("init_quiet", 1'b0, 1'b0, 1'b0, 32'h0, 8'h0);
    end
    idle();
  endtask

  initial begin
    reset = 1'b1;
    garbage();
    step();
    expect_out("reset_state", 1'b0, 1'b0, 1'b0, 32'h0, 8'h0);
    reset = 1'b0;
    sweep_check();
    pred_valid = 1'b1; pred_pc = 32'h100;
    expect_out("ready_cold_btb", 1'b1, 1'b0, 1'b0, 32'h0, 8'h0);

    step();
    upd(32'h100, 8'h00, 1'b1, 32'h80, 1'b0);
    expect_out("miss_no_shift", 1'b1, 1'b0, 1'b0, 32'h0, 8'h0);
    step();
    pred_valid = 1'b0;
    expect_out("btb_hit_after_upd", 1'b1, 1'b1, 1'b1, 32'h80, 8'h0);
    step();
    upd(32'h100, 8'h0F, 1'b1, 32'h80, 1'b0);
    expect_out("ctr_strong", 1'b1, 1'b1, 1'b1, 32'h80, 8'h0);
    step();
    upd(32'h100, 8'h07, 1'b1, 32'h80, 1'b1);
    expect_out("pre_repair", 1'b1, 1'b1, 1'b1, 32'h80, 8'h0);
    step();
    upd_valid = 1'b0; pred_valid = 1'b1;
    expect_out("ghr_snapshot", 1'b1, 1'b1, 1'b1, 32'h80, 8'h0F);
    step();
    upd(32'h100, 8'hA5, 1'b0, 32'h0, 1'b1);
    expect_out("ghr_shifted", 1'b1, 1'b1, 1'b0, 32'h80, 8'h1F);
    step();
    pred_valid = 1'b0;
    upd(32'h200, 8'h4A, 1'b1, 32'h300, 1'b0);
    expect_out("repair_priority", 1'b1, 1'b1, 1'b0, 32'h80, 8'h4A);

    step();
    pred_pc = 32'h200;
    upd(32'h200, 8'h4A, 1'b0, 32'h0, 1'b0);
    expect_out("nt_ctr_10", 1'b1, 1'b1, 1'b1, 32'h300, 8'h4A);
    step();
    expect_out("nt_ctr_01", 1'b1, 1'b1, 1'b0, 32'h300, 8'h4A);
    step();
    expect_out("nt_ctr_00", 1'b1, 1'b1, 1'b0, 32'h300, 8'h4A);
    step();
    expect_out("nt_ctr_00_again", 1'b1, 1'b1, 1'b0, 32'h300, 8'h4A);
    step();
    upd(32'h200, 8'h4A, 1'b1, 32'h300, 1'b0);
    expect_out("ctr_sat_low", 1'b1, 1'b1, 1'b0, 32'h300, 8'h4A);
    step();
    upd_valid = 1'b0;
    expect_out("ctr_climb_01", 1'b1, 1'b1, 1'b0, 32'h300, 8'h4A);
    step();
    pred_pc = 32'h100;
    expect_out("alias_evict", 1'b1, 1'b0, 1'b0, 32'h0, 8'h4A);

    step();
    reset = 1'b1;
    garbage();
    step();
    expect_out("reset_again", 1'b0, 1'b0, 1'b0, 32'h0, 8'h0);
    reset = 1'b0;
    for (int i = 1; i <= 99; i++) step();
    expect_out("mid_init_quiet", 1'b0, 1'b0, 1'b0, 32'h0, 8'h0);
    reset = 1'b1;
    step();
    expect_out("reset_mid_init", 1'b0, 1'b0, 1'b0, 32'h0, 8'h0);
    reset = 1'b0;
    sweep_check();
    pred_valid = 1'b1; pred_pc = 32'h200;
    expect_out("rerun_cold_btb", 1'b1, 1'b0, 1'b0, 32'h0, 8'h0);

    step();
    for (int i = 0; i < 10 && q.size() > 0; i++) step();
    if (q.size() > 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain: %0d expectations left unchecked, want 0", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
